regfile_np: RTL
===============

# regfile_np

Parametrised register file succeeding the single-register, decoder and mux primitives of the misc library. It provides `m` registers of `k` bits, one write port and two independent read ports. The write port has an optional sign-extending write mode and an optional same-cycle write-to-read bypass. A per-register "written since reset" bitmap is exported for the datapath controller. It sits in the datapath between the writeback mux and the ALU operand registers.

## Interface
- `k`, 16, register width in bits
- `n`, 3, address width in bits
- `m`, 8, number of registers; must satisfy 1 ≤ m ≤ 2^n
- `l`, 8, narrow-write width for sign-extend mode; must satisfy 1 ≤ l ≤ k
- `BYPASS`, 1, 1 = same-cycle write-to-read forwarding, 0 = no forwarding
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all registers and bitmap
- `write`  in  1  write enable
- `writenum`  in  n  write address
- `data_in`  in  k  write data
- `wsxt`  in  1  1 = write sign-extended `data_in[l-1:0]`; 0 = write `data_in` unchanged
- `readnum_a`  in  n  read address, port A
- `readnum_b`  in  n  read address, port B
- `data_a`  out  k  read data, port A (combinational)
- `data_b`  out  k  read data, port B (combinational)
- `written`  out  m  bit i = 1 once register i has been written since the last reset

## Operation
- Write value: `wval = wsxt ? {(k-l) copies of data_in[l-1], data_in[l-1:0]} : data_in`. When l == k, `wsxt` has no effect.
- On a rising edge with `reset` = 1:
  - all R[i] ← 0 and `written` ← 0;
  - reset takes priority over `write`.
- On a rising edge with `reset` = 0, `write` = 1 and `writenum` < m:
  - R[writenum] ← wval;
  - `written[writenum]` ← 1;
  - no other register changes.
- Writes with `writenum` ≥ m are ignored: no state change.
- Reads:
  - `data_x` = R[readnum_x] when readnum_x < m;
  - `data_x` = 0 when readnum_x ≥ m.
  - Both ports are fully independent and may address the same register.
- Bypass, BYPASS = 1: if `write` = 1, `reset` = 0, `writenum` < m and `readnum_x` == `writenum`, then `data_x` = wval in the same cycle. This applies to each port independently.
- BYPASS = 0: reads always return the stored value from before the edge.
- Rewriting a register leaves its `written` bit at 1. The bit clears only on reset.

## Timing
- Reset values, one cycle after `reset` is sampled high: R[*] = 0, `data_a` = `data_b` = 0, `written` = 0.
- Write latency:
  - the stored value is visible on read ports immediately after the capturing edge (0 cycles after the edge);
  - with BYPASS = 1 it is also visible combinationally in the write cycle.
- Read latency is 0 cycles (combinational from `readnum_x` and state).
- Reset asserted in the same cycle as `write`: the write is dropped, registers clear, and no bypass occurs (`data_x` shows the old stored value until the edge).
- Back-to-back writes to the same address: the last one wins; each edge captures that cycle's wval.
- No internal pipeline. Throughput is one write per cycle with no stalls or handshake.

## Test plan
- Reset check (k=16, n=3, m=8): hold `reset` 1 for one edge with `write`=1, `writenum`=2, `data_in`=16'h1234 → all reads return 16'h0000, `written`=8'h00.
- Plain write and dual read: write R3←16'hBEEF, then R5←16'h0042 with `wsxt`=0 → next cycle readnum_a=3, readnum_b=5 gives `data_a`=16'hBEEF, `data_b`=16'h0042, `written`=8'h28.
- Sign-extend writes (l=8): `data_in`=16'h12F0, `wsxt`=1 to R1 → R1 reads 16'hFFF0; `data_in`=16'hAB7F, `wsxt`=1 to R2 → R2 reads 16'h007F.
- Bypass, BYPASS=1: with R4=16'h0001 stored, drive `write`=1, `writenum`=4, `data_in`=16'h5555, readnum_a=4 → `data_a`=16'h5555 before the edge.
  - Same stimulus with BYPASS=0 → `data_a`=16'h0001 before the edge and 16'h5555 after it.
- Out-of-range (m=6, n=3): write to address 7 → no register or `written` change; readnum_a=6 → `data_a`=0.
- Mid-operation reset: after populating R0–R7, assert `reset` together with a write to R0 → after the edge every read is 0 and `written`=0. The next write to R0 then sets `written`=8'h01.

Source files
------------

// File: rtl/regfile_np.sv
// Parametrised m x k register file: one write port (optional sign-extend), two
// combinational read ports, optional same-cycle write forwarding, written bitmap.
module regfile_np #(
  parameter int unsigned k      = 16,
  parameter int unsigned n      = 3,
  parameter int unsigned m      = 8,
  parameter int unsigned l      = 8,
  parameter bit          BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write,
  input  logic [n-1:0] writenum,
  input  logic [k-1:0] data_in,
  input  logic         wsxt,
  input  logic [n-1:0] readnum_a,
  input  logic [n-1:0] readnum_b,
  output logic [k-1:0] data_a,
  output logic [k-1:0] data_b,
  output logic [m-1:0] written
);

  logic [k-1:0] regs [m];
  logic [k-1:0] sx_val;
  logic [k-1:0] wval;
  logic         wr_hit;
  logic         wr_ok;

  // Narrow write is only meaningful when l < k; otherwise it degenerates to data_in.
  if (l < k) begin : g_sx
    assign sx_val = {{(k-l){data_in[l-1]}}, data_in[l-1:0]};
  end else begin : g_nosx
    assign sx_val = data_in;
  end

  assign wval = wsxt ? sx_val : data_in;

  // Address match against implemented registers only; out-of-range writes are dropped.
  always_comb begin
    wr_hit = 1'b0;
    for (int unsigned i = 0; i < m; i++) begin
      if (writenum == n'(i)) wr_hit = 1'b1;
    end
  end

  assign wr_ok = write & ~reset & wr_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < m; i++) regs[i] <= '0;
      written <= '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < m; i++) begin
        if (writenum == n'(i)) begin
          regs[i]    <= wval;
          written[i] <= 1'b1;
        end
      end
    end
  end

  // Read muxes: unimplemented addresses read as zero, forwarding overrides storage.
  always_comb begin
    data_a = '0;
    data_b = '0;
    for (int unsigned i = 0; i < m; i++) begin
      if (readnum_a == n'(i)) data_a = regs[i];
      if (readnum_b == n'(i)) data_b = regs[i];
    end
    if (BYPASS && wr_ok && (readnum_a == writenum)) data_a = wval;
    if (BYPASS && wr_ok && (readnum_b == writenum)) data_b = wval;
  end

endmodule
